mc_alu: RTL and testbench

MC_ALU -- requirements
Module: mc_alu

---
 rtl/mc_alu.sv | 136 +++++++++++++
 tb/tb_mc_alu.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_alu.sv
// Multi-cycle ALU. Single-cycle arithmetic/logic ops write result directly;
// MULT (shift-add) and DIV (restoring) iterate one bit per cycle into HI/LO.
module mc_alu #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [3:0] OP_DIV  = 4'd8;
  localparam logic [3:0] OP_MULT = 4'd9;

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] opnd, work_hi, work_lo;
  logic [WIDTH-1:0] alu_out, step_hi, step_lo, div_diff;
  logic [WIDTH:0]   mul_sum, div_shift;
  logic             last;

  assign last = (cnt == CNT_W'(WIDTH - 1));
  assign zero = (result == '0);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    alu_out = '0;
    case (alu_control)
      4'd0, 4'd5, 4'd12, 4'd13: alu_out = a + b;
      4'd2:    alu_out = a & b;
      4'd3:    alu_out = a | b;
      4'd4:    alu_out = ~(a | b);
      4'd6:    alu_out = a - b;
      4'd7:    alu_out = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      4'd10:   alu_out = hi;
      4'd11:   alu_out = lo;
      default: alu_out = '0;
    endcase
  end

  // MUL: {work_hi, work_lo} is the partial product with the multiplier in the
  // low half. DIV: work_hi is the remainder, work_lo shifts dividend out and
  // quotient bits in.
  always_comb begin
    mul_sum   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, opnd} : '0);
    div_shift = {work_hi, work_lo[WIDTH-1]};
    div_diff  = div_shift[WIDTH-1:0] - opnd;
    step_hi   = mul_sum[WIDTH:1];
    step_lo   = {mul_sum[0], work_lo[WIDTH-1:1]};
    if (state == DIV) begin
      if (div_shift >= {1'b0, opnd}) begin
        step_hi = div_diff;
        step_lo = {work_lo[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = div_shift[WIDTH-1:0];
        step_lo = {work_lo[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start && alu_control == OP_MULT)     state_next = MUL;
        else if (start && alu_control == OP_DIV) state_next = DIV;
      end
      MUL, DIV: if (last) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result  <= '0;
      hi      <= '0;
      lo      <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      cnt     <= '0;
      opnd    <= '0;
      work_hi <= '0;
      work_lo <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (alu_control == OP_MULT || alu_control == OP_DIV) begin
              busy    <= 1'b1;
              cnt     <= '0;
              opnd    <= b;
              work_hi <= '0;
              work_lo <= a;
            end else begin
              result <= alu_out;
              done   <= 1'b1;
            end
          end
        end
        MUL, DIV: begin
          cnt     <= cnt + CNT_W'(1);
          work_hi <= step_hi;
          work_lo <= step_lo;
          if (last) begin
            hi     <= step_hi;
            lo     <= step_lo;
            result <= step_lo;
            done   <= 1'b1;
            busy   <= 1'b0;
            cnt    <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_alu.sv
// Self-checking bench for mc_alu: directed corner cases at WIDTH=32, then
// random sweeps at WIDTH=32 and WIDTH=8 against an arithmetic reference model.
module tb_mc_alu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  alu_control;
  logic [31:0] a, b;
  bit          use8;

  logic [31:0] result32, hi32, lo32;
  logic        zero32, busy32, done32;
  logic [7:0]  result8, hi8, lo8;
  logic        zero8, busy8, done8;
  logic        start32, start8;

  logic [31:0] result_o, hi_o, lo_o;
  logic        zero_o, busy_o, done_o;

  always #5 clk = ~clk;

  assign start32 = start & ~use8;
  assign start8  = start & use8;

  mc_alu #(.WIDTH(32), .CNT_W(6)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .alu_control(alu_control),
    .a(a), .b(b), .result(result32), .zero(zero32), .busy(busy32),
    .done(done32), .hi(hi32), .lo(lo32)
  );

  mc_alu #(.WIDTH(8), .CNT_W(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .alu_control(alu_control),
    .a(a[7:0]), .b(b[7:0]), .result(result8), .zero(zero8), .busy(busy8),
    .done(done8), .hi(hi8), .lo(lo8)
  );

  assign result_o = use8 ? {24'd0, result8} : result32;
  assign hi_o     = use8 ? {24'd0, hi8} : hi32;
  assign lo_o     = use8 ? {24'd0, lo8} : lo32;
  assign zero_o   = use8 ? zero8 : zero32;
  assign busy_o   = use8 ? busy8 : busy32;
  assign done_o   = use8 ? done8 : done32;

  int n_cmp = 0;
  int n_err = 0;
  int cur_op = 0;
  int n_acc[2];
  int n_done[2];
  longint unsigned m_hi[2];
  longint unsigned m_lo[2];

  initial begin
    n_done[0] = 0;
    n_done[1] = 0;
  end

  always @(negedge clk) begin
    if (done32 === 1'b1) n_done[0]++;
    if (done8 === 1'b1)  n_done[1]++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s (w=%0d op=%0d): observed %0h expected %0h",
             tag, use8 ? 8 : 32, cur_op, obs, exp);
    end
  endtask

  // Reference model works on whole integers; the DUT is then driven and checked.
  task automatic run_op(input logic [3:0] op, input longint unsigned av_in,
                        input longint unsigned bv_in, input bit poke);
    int              idx, w, cyc;
    longint unsigned mask, av, bv, r, prod;
    longint          sa, sb;
    bit              multi;
    idx    = use8 ? 1 : 0;
    w      = use8 ? 8 : 32;
    mask   = (64'd1 << w) - 64'd1;
    av     = av_in & mask;
    bv     = bv_in & mask;
    multi  = (op == 4'd8 || op == 4'd9);
    cur_op = int'(op);
    sa     = (av > (mask >> 1)) ? longint'(av) - longint'(mask) - 1 : longint'(av);
    sb     = (bv > (mask >> 1)) ? longint'(bv) - longint'(mask) - 1 : longint'(bv);
    case (op)
      4'd0, 4'd5, 4'd12, 4'd13: r = (av + bv) & mask;
      4'd2:  r = av & bv;
      4'd3:  r = av | bv;
      4'd4:  r = ~(av | bv) & mask;
      4'd6:  r = (av - bv) & mask;
      4'd7:  r = (sa < sb) ? 64'd1 : 64'd0;
      4'd8: begin
        if (bv == 0) begin
          m_lo[idx] = mask;
          m_hi[idx] = av;
        end else begin
          m_lo[idx] = av / bv;
          m_hi[idx] = av % bv;
        end
        r = m_lo[idx];
      end
      4'd9: begin
        prod      = av * bv;
        m_hi[idx] = prod >> w;
        m_lo[idx] = prod & mask;
        r         = m_lo[idx];
      end
      4'd10: r = m_hi[idx];
      4'd11: r = m_lo[idx];
      default: r = 64'd0;
    endcase

    @(negedge clk);
    start       = 1'b1;
    alu_control = op;
    a           = av[31:0];
    b           = bv[31:0];
    @(posedge clk);
    #1;
    start = 1'b0;
    n_acc[idx]++;
    if (multi) begin
      check("busy_on", busy_o, 1);
      check("done_early", done_o, 0);
      cyc = 0;
      while (done_o !== 1'b1 && cyc < w + 8) begin
        if (poke) begin
          start       = 1'b1;
          alu_control = 4'($urandom_range(0, 15));
          a           = $urandom;
          b           = $urandom;
        end
        @(posedge clk);
        #1;
        cyc++;
      end
      start = 1'b0;
      check("latency", cyc, w);
      check("busy_off", busy_o, 0);
    end else begin
      check("done_1cyc", done_o, 1);
      check("busy_single", busy_o, 0);
    end
    check("result", result_o, r);
    check("zero", zero_o, (r == 0) ? 1 : 0);
    check("hi", hi_o, m_hi[idx]);
    check("lo", lo_o, m_lo[idx]);
    @(posedge clk);
    #1;
    check("done_pulse", done_o, 0);
  endtask

  function automatic longint unsigned pick_val();
    case ($urandom_range(0, 7))
      0:       return 64'd0;
      1:       return 64'hFFFF_FFFF;
      2:       return 64'd1;
      3:       return 64'h8000_0080;
      default: return longint'($urandom);
    endcase
  endfunction

  initial begin
    int done_snap;
    use8        = 1'b0;
    start       = 1'b0;
    alu_control = 4'd0;
    a           = '0;
    b           = '0;
    n_acc[0]    = 0;
    n_acc[1]    = 0;
    m_hi[0]     = 0; m_hi[1] = 0;
    m_lo[0]     = 0; m_lo[1] = 0;
    rst_n       = 1'b1;
    #1 rst_n    = 1'b0;
    #1;
    check("rst_result", result_o, 0);
    check("rst_zero", zero_o, 1);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_hi", hi_o, 0);
    check("rst_lo", lo_o, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed corner cases at WIDTH=32.
    run_op(4'd0, 64'h7FFF_FFFF, 64'd1, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    check("result_hold", result_o, 64'h8000_0000);
    run_op(4'd6, 64'd5, 64'd5, 1'b0);
    run_op(4'd7, 64'hFFFF_FFFF, 64'd1, 1'b0);
    run_op(4'd7, 64'd1, 64'hFFFF_FFFF, 1'b0);
    run_op(4'd4, 64'd0, 64'd0, 1'b0);
    run_op(4'd2, 64'hF0F0_1234, 64'h0FF0_FF00, 1'b0);
    run_op(4'd3, 64'hF0F0_1234, 64'h0FF0_FF00, 1'b0);
    run_op(4'd14, 64'd7, 64'd9, 1'b0);
    run_op(4'd9, 64'hFFFF_FFFF, 64'd2, 1'b0);
    run_op(4'd10, 64'd0, 64'd0, 1'b0);
    run_op(4'd11, 64'd0, 64'd0, 1'b0);
    run_op(4'd8, 64'd100, 64'd7, 1'b0);
    run_op(4'd8, 64'd9, 64'd0, 1'b1);
    run_op(4'd10, 64'd0, 64'd0, 1'b0);

    // Reset in the middle of a MULT: immediate clear, no done, no HI/LO update.
    done_snap   = n_done[0];
    @(negedge clk);
    start       = 1'b1;
    alu_control = 4'd9;
    a           = 32'd3;
    b           = 32'd4;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_result", result_o, 0);
    check("abort_zero", zero_o, 1);
    check("abort_busy", busy_o, 0);
    check("abort_done", done_o, 0);
    check("abort_hi", hi_o, 0);
    check("abort_lo", lo_o, 0);
    m_hi[0] = 0; m_lo[0] = 0;
    m_hi[1] = 0; m_lo[1] = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("abort_no_done", n_done[0], done_snap);
    run_op(4'd11, 64'd0, 64'd0, 1'b0);

    // Random sweeps at both widths.
    for (int i = 0; i < 1000; i++)
      run_op(4'($urandom_range(0, 15)), pick_val(), pick_val(), ($urandom_range(0, 3) == 0));
    @(negedge clk);
    use8 = 1'b1;
    for (int i = 0; i < 1000; i++)
      run_op(4'($urandom_range(0, 15)), pick_val(), pick_val(), ($urandom_range(0, 3) == 0));

    @(negedge clk);
    check("done_count32", n_done[0], n_acc[0]);
    check("done_count8", n_done[1], n_acc[1]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
